// File: rtl/wall_scroller_pkg.sv
// Shared types and default geometry for the wall scroller and its queue.
package wall_scroller_pkg;

  localparam int X_W             = 8;
  localparam int H_W             = 8;
  localparam int SCREEN_W_DEF    = 160;
  localparam int WALL_SPACING_DEF = 48;
  localparam int SCROLL_STEP_DEF = 1;
  localparam int MAX_WALLS_DEF   = 4;
  localparam int BIRD_X_DEF      = 40;
  localparam int MIN_H_DEF       = 8;
  localparam int MAX_H_DEF       = 80;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    STOP
  } state_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [H_W-1:0] h;
  } wall_t;

  function automatic logic [H_W-1:0] clamp_height(input logic [H_W-1:0] raw,
                                                  input logic [H_W-1:0] lo,
                                                  input logic [H_W-1:0] hi);
    if (raw < lo) return lo;
    if (raw > hi) return hi;
    return raw;
  endfunction

endpackage

// File: rtl/wall_scroller_if.sv
// Valid/ready height stream from the wall height generator to the scroller.
interface wall_scroller_if;
  logic       height_valid;
  logic [7:0] height_data;
  logic       height_ready;

  modport master (output height_valid, output height_data, input height_ready);
  modport slave  (input height_valid, input height_data, output height_ready);
endinterface

// File: rtl/wall_scroller_fifo.sv
// Circular wall queue: push at tail, pop at head, parallel x decrement on
// scroll, registered indexed read, and a view of every slot for score detection.
module wall_scroller_fifo
  import wall_scroller_pkg::*;
#(
  parameter int DEPTH = MAX_WALLS_DEF,
  parameter int STEP  = SCROLL_STEP_DEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     push,
  input  wall_t                    push_entry,
  input  logic                     scroll,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [X_W-1:0]           rd_x,
  output logic [H_W-1:0]           rd_h,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic [X_W-1:0]           newest_x,
  output logic [DEPTH-1:0]         occupied,
  output wall_t                    entries [DEPTH]
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [X_W-1:0] STEP_X = X_W'(STEP);

  wall_t         mem [DEPTH];
  logic [IW-1:0] head;
  logic [IW-1:0] tail;
  logic [IW-1:0] newest;
  logic [IW-1:0] rd_slot;
  logic          pop;

  assign tail     = head + count[IW-1:0];
  assign newest   = tail - IW'(1);
  assign rd_slot  = head + rd_idx;
  assign newest_x = mem[newest].x;
  assign entries  = mem;

  // Only the oldest wall can have run off the left edge, so only head is tested for retirement.
  assign pop = scroll && (count != '0) && (mem[head].x < STEP_X);

  // A slot is live when its distance from head is below the current count.
  always_comb begin
    occupied = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupied[i] = {1'b0, IW'(i) - head} < count;
    end
  end

  // Storage and pointers: flush empties, scroll slides every x left, push fills the tail slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      count <= '0;
    end else begin
      if (scroll) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem[i].x <= (mem[i].x >= STEP_X) ? (mem[i].x - STEP_X) : '0;
        end
      end
      if (push) begin
        mem[tail] <= push_entry;
      end
      if (pop) begin
        head <= head + IW'(1);
      end
      count <= count + {{IW{1'b0}}, push} - {{IW{1'b0}}, pop};
    end
  end

  // Registered read port, zeroed when the requested index is beyond the live walls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_valid <= 1'b0;
      rd_x     <= '0;
      rd_h     <= '0;
    end else if ({1'b0, rd_idx} < count) begin
      rd_valid <= 1'b1;
      rd_x     <= mem[rd_slot].x;
      rd_h     <= mem[rd_slot].h;
    end else begin
      rd_valid <= 1'b0;
      rd_x     <= '0;
      rd_h     <= '0;
    end
  end

endmodule

// File: rtl/wall_scroller.sv
// Consumer of the wall height stream: run-state FSM, handshake, height clamp,
// scroll control and score detection around the circular wall queue.
module wall_scroller
  import wall_scroller_pkg::*;
#(
  parameter int SCREEN_W     = SCREEN_W_DEF,
  parameter int WALL_SPACING = WALL_SPACING_DEF,
  parameter int SCROLL_STEP  = SCROLL_STEP_DEF,
  parameter int MAX_WALLS    = MAX_WALLS_DEF,
  parameter int BIRD_X       = BIRD_X_DEF,
  parameter int MIN_H        = MIN_H_DEF,
  parameter int MAX_H        = MAX_H_DEF
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         frame_tick,
  wall_scroller_if.slave               hs,
  input  logic [$clog2(MAX_WALLS)-1:0] rd_idx,
  output logic [X_W-1:0]               rd_x,
  output logic [H_W-1:0]               rd_h,
  output logic                         rd_valid,
  output logic [$clog2(MAX_WALLS):0]   wall_count,
  output logic                         score_pulse,
  output logic                         running
);

  localparam int CW = $clog2(MAX_WALLS) + 1;
  localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_WALLS);
  localparam logic [X_W-1:0] SPAWN_X = X_W'(SCREEN_W - 1);
  localparam logic [X_W-1:0] READY_X = X_W'(SCREEN_W - 1 - WALL_SPACING);
  localparam logic [X_W-1:0] BIRD_XV = X_W'(BIRD_X);
  localparam logic [X_W-1:0] STEP_X  = X_W'(SCROLL_STEP);
  localparam logic [H_W-1:0] MIN_HV  = H_W'(MIN_H);
  localparam logic [H_W-1:0] MAX_HV  = H_W'(MAX_H);

  state_t         state;
  logic           ready;
  logic           transfer;
  logic           push;
  logic           scroll;
  logic           flush;
  logic           pass_hit;
  wall_t          new_wall;
  logic [X_W-1:0] newest_x;
  logic [MAX_WALLS-1:0] occupied;
  wall_t          entries [MAX_WALLS];

  assign hs.height_ready = ready;
  assign transfer = hs.height_valid && ready;
  assign push     = transfer && !((state == RUN) && stop);
  assign scroll   = (state == RUN) && frame_tick && !stop;
  assign flush    = ((state == IDLE) || (state == STOP)) && start;
  assign new_wall = '{x: SPAWN_X, h: clamp_height(hs.height_data, MIN_HV, MAX_HV)};

  // Ready depends only on registered state so the generator never sees a combinational loop.
  always_comb begin
    ready = 1'b0;
    case (state)
      FILL:    ready = 1'b1;
      RUN:     ready = (wall_count < MAX_CNT) &&
                       ((wall_count == '0) || (newest_x <= READY_X));
      default: ready = 1'b0;
    endcase
  end

  // A wall scores on the tick that carries it from right of the bird column onto or past it.
  always_comb begin
    pass_hit = 1'b0;
    for (int i = 0; i < MAX_WALLS; i++) begin
      if (occupied[i] && (entries[i].x > BIRD_XV) && ((entries[i].x - STEP_X) <= BIRD_XV)) begin
        pass_hit = 1'b1;
      end
    end
  end

  // Run-state machine with running registered alongside the state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state   <= FILL;
          running <= 1'b1;
        end
        FILL: if (transfer) begin
          state <= RUN;
        end
        RUN: if (stop) begin
          state   <= STOP;
          running <= 1'b0;
        end
        STOP: if (start) begin
          state   <= FILL;
          running <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  // Score pulse follows the scrolling tick by one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      score_pulse <= 1'b0;
    end else begin
      score_pulse <= scroll && pass_hit;
    end
  end

  wall_scroller_fifo #(
    .DEPTH (MAX_WALLS),
    .STEP  (SCROLL_STEP)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .push       (push),
    .push_entry (new_wall),
    .scroll     (scroll),
    .rd_idx     (rd_idx),
    .rd_x       (rd_x),
    .rd_h       (rd_h),
    .rd_valid   (rd_valid),
    .count      (wall_count),
    .newest_x   (newest_x),
    .occupied   (occupied),
    .entries    (entries)
  );

endmodule
